dff_reg_arbiter: RTL and testbench



---
 rtl/dff_reg_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dff_reg_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dff_reg_arbiter.sv
// ---------------------------------------------------------------------------
// dff_reg_arbiter
//
// Round-robin arbiter that shares one WIDTH-bit register bank (built from
// Dff cells, instantiated outside this block) among four requesters. A
// requester wins write ownership through a registered req/gnt handshake and
// keeps it for at most HOLD consecutive GRANT cycles. While it owns the bank,
// this block steers that requester's data onto the bank's shared d bus and
// drives the bank's load enable.
//
// Ownership life cycle: IDLE -> GRANT (1..HOLD cycles) -> RELEASE (1 cycle)
// -> IDLE. The pointer of highest priority moves to owner+1 on every release,
// so four continuous requesters are served 0,1,2,3,0,...
//
// Parameters
//   WIDTH  data width of the shared register
//   HOLD   maximum consecutive GRANT cycles per ownership (1..15)
//
// Ports
//   clk     in   system clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset
//   req     in   [3:0] level-sensitive write requests
//   wdata   in   [4*WIDTH-1:0] requester data, requester i at [i*WIDTH +: WIDTH]
//   gnt     out  [3:0] registered one-hot grant (zero outside GRANT)
//   owner   out  [1:0] registered index of the current or last grantee
//   busy    out  high in GRANT or RELEASE
//   reg_d   out  [WIDTH-1:0] data bus to the register bank d inputs
//   reg_en  out  load enable to the register bank
// ---------------------------------------------------------------------------
module dff_reg_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         gnt,
    output logic [1:0]         owner,
    output logic               busy,
    output logic [WIDTH-1:0]   reg_d,
    output logic               reg_en
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [3:0] HOLD_C = 4'(HOLD);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;

    // -----------------------------------------------------------------------
    // Rotating priority pick: first set request in the order
    // ptr, ptr+1, ptr+2, ptr+3 (2-bit arithmetic wraps modulo 4).
    // -----------------------------------------------------------------------
    logic       pick_valid;
    logic [1:0] pick_idx;

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!pick_valid && req[ptr_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr_q + 2'(k);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic owner_req;
    assign owner_req = req[owner_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = 4'(4'b0001 << pick_idx);
                    cnt_d   = 4'd1;
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Leave on an early drop by the owner or when the ownership
                // budget is spent; cnt therefore never climbs past HOLD.
                if (!owner_req || (cnt_q == HOLD_C)) begin
                    gnt_d   = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_RELEASE: begin
                // Turnaround cycle: requests are ignored here.
                gnt_d   = 4'b0000;
                state_d = ST_IDLE;
            end

            default: begin
                gnt_d   = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. gnt, owner and busy come only from flops. reg_en follows the
    // owner's live request so an early drop stops the load in the same cycle.
    // -----------------------------------------------------------------------
    logic in_grant;
    assign in_grant = (state_q == ST_GRANT);

    assign gnt    = gnt_q;
    assign owner  = owner_q;
    assign busy   = (state_q == ST_GRANT) || (state_q == ST_RELEASE);
    assign reg_en = in_grant && owner_req;
    assign reg_d  = in_grant ? wdata[owner_q*WIDTH +: WIDTH] : '0;

    // -----------------------------------------------------------------------
    // Structural invariants of the grant vector
    // -----------------------------------------------------------------------
    gnt_onehot0_a : assert property (@(posedge clk) disable iff (reset)
        $onehot0(gnt_q));

    gnt_only_in_grant_a : assert property (@(posedge clk) disable iff (reset)
        (gnt_q != 4'b0000) |-> in_grant);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_reg_arbiter
//
// Directed bench for dff_reg_arbiter. Two instances share clk and reset:
// u_dut2 with HOLD=2 covers reset, single requester, round robin, early drop
// and reset mid-grant; u_dut1 with HOLD=1 covers 1-cycle grants and the
// pointer wrap from 3 to 0. Inputs change and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_dff_reg_arbiter;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;

    logic [3:0]         req2,   req1;
    logic [4*WIDTH-1:0] wdata2, wdata1;
    logic [3:0]         gnt2,   gnt1;
    logic [1:0]         owner2, owner1;
    logic               busy2,  busy1;
    logic [WIDTH-1:0]   reg_d2, reg_d1;
    logic               reg_en2, reg_en1;

    int n_cmp;
    int n_err;

    dff_reg_arbiter #(.WIDTH(WIDTH), .HOLD(2)) u_dut2 (
        .clk    (clk),
        .reset  (reset),
        .req    (req2),
        .wdata  (wdata2),
        .gnt    (gnt2),
        .owner  (owner2),
        .busy   (busy2),
        .reg_d  (reg_d2),
        .reg_en (reg_en2)
    );

    dff_reg_arbiter #(.WIDTH(WIDTH), .HOLD(1)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .req    (req1),
        .wdata  (wdata1),
        .gnt    (gnt1),
        .owner  (owner1),
        .busy   (busy1),
        .reg_d  (reg_d1),
        .reg_en (reg_en1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Snapshot of the HOLD=2 instance against expected values.
    task automatic check2(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_owner,
                          input logic e_busy, input logic e_en, input logic [7:0] e_d);
        check({tag, ".gnt"},    32'(gnt2),    32'(e_gnt));
        check({tag, ".owner"},  32'(owner2),  32'(e_owner));
        check({tag, ".busy"},   32'(busy2),   32'(e_busy));
        check({tag, ".reg_en"}, 32'(reg_en2), 32'(e_en));
        check({tag, ".reg_d"},  32'(reg_d2),  32'(e_d));
    endtask

    // Expected gnt per cycle for four continuous requesters with HOLD=2.
    logic [3:0] rr_exp [1:18];

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        req2   = 4'b1111;
        req1   = 4'b1111;
        wdata2 = {8'h33, 8'hA5, 8'h11, 8'h5C};
        wdata1 = {8'hC3, 8'h77, 8'h66, 8'h3E};

        rr_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0000,
                   4'b0010, 4'b0010, 4'b0000, 4'b0000,
                   4'b0100, 4'b0100, 4'b0000, 4'b0000,
                   4'b1000, 4'b1000, 4'b0000, 4'b0000,
                   4'b0001, 4'b0001};

        // ---- Reset and idle: requests are ignored while reset is high ----
        repeat (2) begin
            @(negedge clk);
            check2("rst", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
        end
        reset = 1'b0;
        req2  = 4'b0000;
        req1  = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            check2("idle", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
        end

        // ---- Single requester 2, HOLD=2 ----
        req2 = 4'b0100;
        @(negedge clk);
        check2("single.g1", 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5);
        @(negedge clk);
        check2("single.g2", 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5);
        @(negedge clk);
        check2("single.rel", 4'b0000, 2'd2, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check2("single.idle", 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check2("single.regrant", 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5);
        req2 = 4'b0000;
        #1;
        check("single.drop_en", 32'(reg_en2), 32'd0);
        @(negedge clk);
        check2("single.drop_rel", 4'b0000, 2'd2, 1'b1, 1'b0, 8'h00);

        // ---- Round robin from reset release ----
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req2  = 4'b1111;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            check($sformatf("rr.gnt[%0d]", k), 32'(gnt2), 32'(rr_exp[k]));
        end
        check("rr.owner_end", 32'(owner2), 32'd0);

        // ---- Early drop by requester 1 ----
        reset = 1'b1;
        req2  = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        req2  = 4'b0010;
        @(negedge clk);
        check2("drop.grant", 4'b0010, 2'd1, 1'b1, 1'b1, 8'h11);
        req2 = 4'b0101;
        #1;
        check("drop.en_same_cycle", 32'(reg_en2), 32'd0);
        check("drop.gnt_still", 32'(gnt2), 32'(4'b0010));
        @(negedge clk);
        check2("drop.rel", 4'b0000, 2'd1, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check2("drop.idle", 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check2("drop.ptr2_wins", 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5);

        // ---- Reset mid-grant with owner 3 ----
        reset = 1'b1;
        req2  = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        req2  = 4'b1000;
        @(negedge clk);
        check2("midrst.grant3", 4'b1000, 2'd3, 1'b1, 1'b1, 8'h33);
        reset = 1'b1;
        req2  = 4'b1001;
        @(negedge clk);
        check2("midrst.cleared", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        check2("midrst.req0_first", 4'b0001, 2'd0, 1'b1, 1'b1, 8'h5C);

        // ---- HOLD=1 instance: 1-cycle grants for 3, then wrap to 0 ----
        req1 = 4'b1000;
        @(negedge clk);
        check("h1.g3a.gnt", 32'(gnt1), 32'(4'b1000));
        check("h1.g3a.reg_en", 32'(reg_en1), 32'd1);
        check("h1.g3a.reg_d", 32'(reg_d1), 32'h0000_00C3);
        @(negedge clk);
        check("h1.rel_a.gnt", 32'(gnt1), 32'd0);
        check("h1.rel_a.busy", 32'(busy1), 32'd1);
        @(negedge clk);
        check("h1.idle_a.busy", 32'(busy1), 32'd0);
        @(negedge clk);
        check("h1.g3b.gnt", 32'(gnt1), 32'(4'b1000));
        req1 = 4'b1001;
        @(negedge clk);
        check("h1.rel_b.gnt", 32'(gnt1), 32'd0);
        @(negedge clk);
        check("h1.idle_b.gnt", 32'(gnt1), 32'd0);
        check("h1.idle_b.owner", 32'(owner1), 32'd3);
        @(negedge clk);
        check("h1.wrap.gnt", 32'(gnt1), 32'(4'b0001));
        check("h1.wrap.owner", 32'(owner1), 32'd0);
        check("h1.wrap.reg_d", 32'(reg_d1), 32'h0000_003E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
